if_fetch_unit: RTL

//  Instruction-fetch stage that feeds the decode stage. Owns the PC, issues requests to instruction memory
//  (variable latency, req/ready + rvalid), buffers returned words, and presents instr/pc_plus4 via the IF/ID register.

---
 rtl/mips_if_pkg.sv | 10 +
 rtl/if_fetch_fifo.sv | 36 +++
 rtl/if_fetch_unit.sv | 92 +++++++++
 3 files changed

// File: rtl/mips_if_pkg.sv
// mips_if_pkg: shared fetch-stage constants and the fetch-buffer entry type
package mips_if_pkg;
  localparam int PC_W = 10;
  localparam logic [PC_W-1:0] RESET_PC = 10'h000;
  localparam logic [31:0] NOP_INSTR = 32'h0;
  typedef struct packed {
    logic [31:0] instr;
    logic [PC_W-1:0] pc_plus4;
  } fetch_entry_t;
endpackage

// File: rtl/if_fetch_fifo.sv
// if_fetch_fifo: synchronous fetch buffer with push/pop/flush and an occupancy count
module if_fetch_fifo
  import mips_if_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  logic flush,
  input  fetch_entry_t wdata,
  output fetch_entry_t rdata,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] rd, wr;
  assign rdata = mem[rd];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else if (flush) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      if (push) wr <= wr + AW'(1);
      if (pop) rd <= rd + AW'(1);
      count <= count + (AW + 1)'(push) - (AW + 1)'(pop);
    end
  always_ff @(posedge clk)
    if (push && !flush) mem[wr] <= wdata;
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: PC, credit-limited imem fetch, redirect/discard and IF/ID register; IF_FETCH_STATS_EN adds counters
module if_fetch_unit
  import mips_if_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic id_stall,
  input  logic branch_taken,
  input  logic [PC_W-1:0] branch_address,
  input  logic jump,
  input  logic [PC_W-1:0] jump_address,
  output logic imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic imem_ready,
  input  logic imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [PC_W-1:0] pc_plus4,
  output logic if_valid,
  output logic control_hazard
`ifdef IF_FETCH_STATS_EN
  ,
  output logic [31:0] fetch_count,
  output logic [15:0] redirect_count
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic [PC_W-1:0] fetch_pc, resp_pc, target;
  logic [CW-1:0] outstanding, discard, occ, out_nx;
  logic accept, push, pop;
  fetch_entry_t head, entry;
  if_fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(pop),
    .flush(control_hazard),
    .wdata(entry),
    .rdata(head),
    .count(occ)
  );
  always_comb begin
    control_hazard = (jump | branch_taken) & !id_stall;
    target = jump ? jump_address : branch_address;
    imem_req = reset && !control_hazard && (int'(outstanding) + int'(occ) < FIFO_DEPTH);
    imem_addr = fetch_pc;
    accept = imem_req & imem_ready;
    push = imem_rvalid & !control_hazard & (discard == '0);
    pop = !id_stall & !control_hazard & (occ != '0);
    out_nx = outstanding + CW'(accept) - CW'(imem_rvalid);
    entry = '{instr: imem_rdata, pc_plus4: resp_pc + PC_W'(4)};
  end
  // resp_pc tracks the address of the next kept response: fetches are sequential between redirects
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      fetch_pc <= RESET_PC;
      resp_pc <= RESET_PC;
      outstanding <= '0;
      discard <= '0;
      instr <= NOP_INSTR;
      pc_plus4 <= '0;
      if_valid <= 1'b0;
    end else begin
      outstanding <= out_nx;
      if (control_hazard) begin
        fetch_pc <= target;
        resp_pc <= target;
        discard <= out_nx;
      end else begin
        if (accept) fetch_pc <= fetch_pc + PC_W'(4);
        if (push) resp_pc <= resp_pc + PC_W'(4);
        if (imem_rvalid && discard != '0) discard <= discard - CW'(1);
      end
      if (!id_stall) begin
        instr <= pop ? head.instr : NOP_INSTR;
        if_valid <= pop;
        if (pop) pc_plus4 <= head.pc_plus4;
      end
    end
`ifdef IF_FETCH_STATS_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      fetch_count <= '0;
      redirect_count <= '0;
    end else begin
      if (pop) fetch_count <= fetch_count + 32'd1;
      if (control_hazard) redirect_count <= redirect_count + 16'd1;
    end
`endif
endmodule
